// File: rtl/barrel_shift_unit.sv
// Operand shifter covering register shifts, rotated immediates and branch
// offsets, behind a 1- or 2-stage valid/ready pipeline.
module barrel_shift_unit #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [1:0]       shift_type,
    input  logic [7:0]       shift_amt,
    input  logic [WIDTH-1:0] rm_data,
    input  logic [11:0]      imm12,
    input  logic [23:0]      branch_offset,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_REG_IMM = 2'b00,
        MODE_REG_REG = 2'b01,
        MODE_IMM_ROT = 2'b10,
        MODE_BRANCH  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [SW-1:0] r);
        logic [SW:0] r_inv;
        r_inv = (SW+1)'(WIDTH) - {1'b0, r};
        return (v >> r) | (v << r_inv);
    endfunction

    logic [8:0]            amt;
    logic [WIDTH:0]        lsl_ext;
    logic [WIDTH:0]        lsr_ext;
    logic signed [WIDTH:0] asr_ext;
    logic [WIDTH-1:0]      ror_data;
    logic [4:0]            imm_rot;
    logic [WIDTH-1:0]      imm_data;
    logic [WIDTH-1:0]      res_data;
    logic                  res_carry;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        amt = {1'b0, shift_amt};
        if (mode == MODE_REG_IMM) begin
            amt = {4'd0, shift_amt[4:0]};
            // A zero immediate field selects the full-width form of LSR and ASR.
            if (shift_amt[4:0] == 5'd0 && (shift_type == SH_LSR || shift_type == SH_ASR))
                amt = 9'(WIDTH);
        end

        // The extra bit beside each operand catches the last bit shifted out.
        lsl_ext  = {1'b0, rm_data} << amt;
        lsr_ext  = {rm_data, 1'b0} >> amt;
        asr_ext  = $signed({rm_data, 1'b0}) >>> amt;
        ror_data = rotr(rm_data, amt[SW-1:0]);
        imm_rot  = {imm12[11:8], 1'b0};
        imm_data = rotr(WIDTH'(imm12[7:0]), SW'(imm_rot));

        res_data  = '0;
        res_carry = carry_in;
        case (mode)
            MODE_REG_IMM, MODE_REG_REG: begin
                if (amt == '0) begin
                    res_data = rm_data;
                    if (mode == MODE_REG_IMM && shift_type == SH_ROR) begin
                        res_data  = {carry_in, rm_data[WIDTH-1:1]};
                        res_carry = rm_data[0];
                    end
                end else begin
                    case (shift_type)
                        SH_LSL:  {res_carry, res_data} = lsl_ext;
                        SH_LSR:  {res_data, res_carry} = lsr_ext;
                        SH_ASR:  {res_data, res_carry} = asr_ext;
                        default: begin
                            res_data  = ror_data;
                            res_carry = ror_data[WIDTH-1];
                        end
                    endcase
                end
            end
            MODE_IMM_ROT: begin
                res_data  = imm_data;
                res_carry = (imm_rot == '0) ? carry_in : imm_data[WIDTH-1];
            end
            MODE_BRANCH: begin
                res_data = {{(WIDTH-26){branch_offset[23]}}, branch_offset, 2'b00};
            end
            default: begin
                res_data  = '0;
                res_carry = 1'b0;
            end
        endcase
    end

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_carry_q, s1_carry_d;
    logic             s1_load;
    logic             s1_down_ready;

    // A stage loads when empty or when its current contents leave this cycle.
    assign s1_load  = !s1_valid_q || s1_down_ready;
    assign in_ready = s1_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_carry_d = s1_carry_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d  = res_data;
                s1_carry_d = res_carry;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; data regs are reset
    // too because the outputs must read zero while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_carry_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_carry_q <= s1_carry_d;
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic             s2_valid_q, s2_valid_d;
            logic [WIDTH-1:0] s2_data_q, s2_data_d;
            logic             s2_carry_q, s2_carry_d;
            logic             s2_load;

            assign s2_load       = !s2_valid_q || out_ready;
            assign s1_down_ready = s2_load;

            always_comb begin
                s2_valid_d = s2_valid_q;
                s2_data_d  = s2_data_q;
                s2_carry_d = s2_carry_q;
                if (s2_load) begin
                    s2_valid_d = s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_d  = s1_data_q;
                        s2_carry_d = s1_carry_q;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    s2_carry_q <= 1'b0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                    s2_carry_q <= s2_carry_d;
                end
            end

            assign out_valid = s2_valid_q;
            assign out_data  = s2_data_q;
            assign out_carry = s2_carry_q;
        end else begin : g_one_stage
            assign s1_down_ready = out_ready;
            assign out_valid     = s1_valid_q;
            assign out_data      = s1_data_q;
            assign out_carry     = s1_carry_q;
        end
    endgenerate

endmodule
